// File: rtl/sram_pkg.sv
// sram_pkg
// Shared constants for the SRAM arbiter slice: controller opcodes, the
// arbiter FSM state encoding and default bus widths.
// No ports (package only).
package sram_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  // Opcodes understood by the SRAM controller.
  localparam logic [3:0] OP_IDLE  = 4'd0;
  localparam logic [3:0] OP_READ  = 4'd10;
  localparam logic [3:0] OP_WRITE = 4'd11;

  // Arbiter FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin pick.
// Ports:
//   req0, req1   : request levels from the two ports
//   last_grant   : id of the port that won the previous arbitration
//   grant_valid  : at least one request is present
//   grant_id     : id of the winning port (only meaningful with grant_valid)
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // A lone requester always wins; on contention the port that did not
  // win last time gets the grant.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one SRAM controller between port 0 (pipeline MEM stage) and
// port 1 (program loader / debug master). The winner's address, data and
// direction are latched, the controller opcode is held for ACCESS_CYCLES
// cycles, read data is captured on the last cycle of the window and a
// one-cycle ack is returned to the owner.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN       : port N request (level), direction, address, write data
//   ackN                           : port N access complete, one-cycle pulse
//   rdataN                         : port N last read data, registered
//   stallN                         : reqN & ~ackN, freezes the requester
//   mem_opcode, mem_addr, mem_wdata: controller command and latched operands
//   mem_rdata                      : read data from the controller
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              stall0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              stall1,
  output logic [3:0]        mem_opcode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              grant_valid;
  logic              grant_id;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_id;
          last_grant_d = grant_id;
          we_d         = grant_id ? we1 : we0;
          addr_d       = grant_id ? addr1 : addr0;
          wdata_d      = grant_id ? wdata1 : wdata0;
          cnt_d        = 4'd0;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 4'd1;
        // The controller's read data is valid on the last cycle of the
        // window, so that is where it is captured for the owner.
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (owner_q) begin
              rdata1_d = mem_rdata;
            end else begin
              rdata0_d = mem_rdata;
            end
          end
        end
      end
      ST_DONE: begin
        // Requests are deliberately not looked at here; re-arbitration
        // happens in the following IDLE cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset mid-access simply drops the access: no ack, rdata back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Outputs decode only registered state, so ack and opcode are glitch-free.
  assign mem_opcode = (state_q == ST_BUSY) ? (we_q ? OP_WRITE : OP_READ) : OP_IDLE;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ack0       = (state_q == ST_DONE) && !owner_q;
  assign ack1       = (state_q == ST_DONE) && owner_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign stall0     = req0 & ~ack0;
  assign stall1     = req1 & ~ack1;

endmodule
